audio_codec_cfg: RTL and testbench



---
 rtl/audio_codec_cfg_pkg.sv | 69 ++++++
 rtl/audio_codec_cfg_i2c.sv | 102 ++++++++++
 rtl/audio_codec_cfg.sv | 190 +++++++++++++++++++
 tb/tb_audio_codec_cfg.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_codec_cfg_pkg.sv
// WM8731 configuration sequencer: shared types, index constants and
// the power-up register table.
package audio_cfg_pkg;

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_LOAD,
    S_XFER,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_ERROR,
    S_VOL_UPD
  } cfg_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_START,
    P_BIT,
    P_STOP
  } i2c_phase_e;

  localparam logic [3:0] IDX_LHP  = 4'd3;
  localparam logic [3:0] IDX_RHP  = 4'd4;
  localparam logic [3:0] IDX_LAST = 4'd10;

  localparam logic [6:0] R_LLIN = 7'h00;
  localparam logic [6:0] R_RLIN = 7'h01;
  localparam logic [6:0] R_LHP  = 7'h02;
  localparam logic [6:0] R_RHP  = 7'h03;
  localparam logic [6:0] R_AAPC = 7'h04;
  localparam logic [6:0] R_DAPC = 7'h05;
  localparam logic [6:0] R_PWR  = 7'h06;
  localparam logic [6:0] R_DAIF = 7'h07;
  localparam logic [6:0] R_SMP  = 7'h08;
  localparam logic [6:0] R_ACT  = 7'h09;
  localparam logic [6:0] R_RST  = 7'h0F;

  function automatic logic [15:0] mk_word(
    input logic [6:0] r,
    input logic [8:0] d
  );
    return {r, d};
  endfunction

  // Headphone entries carry LRHPBOTH|zero-cross above the volume field
  function automatic logic [15:0] cfg_word(
    input logic [3:0] idx,
    input logic [6:0] vol
  );
    logic [15:0] w;
    case (idx)
      4'd0:    w = mk_word(R_RST,  9'h000);
      4'd1:    w = mk_word(R_LLIN, 9'h01A);
      4'd2:    w = mk_word(R_RLIN, 9'h01A);
      4'd3:    w = mk_word(R_LHP,  {2'b11, vol});
      4'd4:    w = mk_word(R_RHP,  {2'b11, vol});
      4'd5:    w = mk_word(R_AAPC, 9'h012);
      4'd6:    w = mk_word(R_DAPC, 9'h006);
      4'd7:    w = mk_word(R_PWR,  9'h000);
      4'd8:    w = mk_word(R_DAIF, 9'h002);
      4'd9:    w = mk_word(R_SMP,  9'h002);
      4'd10:   w = mk_word(R_ACT,  9'h001);
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/audio_codec_cfg_i2c.sv
// Three-byte I2C write engine: START, 3x(8 data + ACK), STOP.
// Each bit is four quarter ticks: SCL low, high, high, low.
import audio_cfg_pkg::*;

module i2c_write3 (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic [23:0] i_payload,
  input  logic        i_sda,
  output logic        o_done,
  output logic [2:0]  o_ack,
  output logic        o_scl,
  output logic        o_sda_oe
);

  i2c_phase_e  r_phase;
  logic [1:0]  r_q;
  logic [3:0]  r_bit;
  logic [1:0]  r_byte;
  logic [23:0] r_sh;
  logic [2:0]  r_ack;
  logic        r_done;

  assign o_done = r_done;
  assign o_ack  = r_ack;

  // Outputs decode straight from state so reset releases the bus at once
  always_comb begin
    o_scl    = 1'b1;
    o_sda_oe = 1'b0;
    unique case (r_phase)
      P_IDLE: ;
      P_START: begin
        o_scl    = (r_q != 2'd3);
        o_sda_oe = (r_q != 2'd0);
      end
      P_BIT: begin
        o_scl    = r_q[0] ^ r_q[1];
        o_sda_oe = (r_bit != 4'd8) && !r_sh[23];
      end
      P_STOP: begin
        o_scl    = (r_q != 2'd0);
        o_sda_oe = !r_q[1];
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_phase <= P_IDLE;
      r_q     <= 2'd0;
      r_bit   <= 4'd0;
      r_byte  <= 2'd0;
      r_sh    <= 24'd0;
      r_ack   <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_phase == P_IDLE) begin
        if (i_start) begin
          r_phase <= P_START;
          r_q     <= 2'd0;
          r_bit   <= 4'd0;
          r_byte  <= 2'd0;
          r_sh    <= i_payload;
          r_ack   <= 3'd0;
        end
      end else if (i_tick) begin
        r_q <= r_q + 2'd1;
        if (r_phase == P_BIT && r_bit == 4'd8 && r_q == 2'd2) begin
          r_ack <= {r_ack[1:0], i_sda};
        end
        if (r_q == 2'd3) begin
          unique case (r_phase)
            P_START: r_phase <= P_BIT;
            P_BIT: begin
              if (r_bit == 4'd8) begin
                r_bit <= 4'd0;
                if (r_byte == 2'd2) begin
                  r_phase <= P_STOP;
                end else begin
                  r_byte <= r_byte + 2'd1;
                end
              end else begin
                r_bit <= r_bit + 4'd1;
                r_sh  <= {r_sh[22:0], 1'b0};
              end
            end
            P_STOP: begin
              r_phase <= P_IDLE;
              r_done  <= 1'b1;
            end
            P_IDLE: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/audio_codec_cfg.sv
// WM8731 power-up/runtime configuration sequencer with NACK retry
// and headphone-volume rewrite on iVOL change.
import audio_cfg_pkg::*;

module audio_codec_cfg #(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          I2C_FREQ  = 20000,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter logic [15:0] POR_DELAY = 16'd50000,
  parameter int          MAX_RETRY = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSTART,
  input  logic [6:0] iVOL,
  output logic       oI2C_SCLK,
  inout  wire        ioI2C_SDAT,
  output logic       oBUSY,
  output logic       oCFG_DONE,
  output logic       oCFG_ERR,
  output logic [3:0] oIDX
);

  localparam int TICK_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  cfg_state_e  r_state, w_nxt;
  logic [15:0] r_tdiv;
  logic [15:0] r_cnt, w_cnt_n;
  logic [3:0]  r_idx, w_idx_n;
  logic [3:0]  r_retry, w_retry_n;
  logic [6:0]  r_vol, w_vol_n;
  logic        r_done, w_done_n;
  logic        r_err, w_err_n;
  logic        r_vmode, w_vmode_n;
  logic        w_tick, w_go, w_xdone, w_sda_oe, w_scl;
  logic [2:0]  w_ack;
  logic [23:0] w_payload;

  assign w_tick    = (r_tdiv == TICK_LAST);
  assign w_payload = {DEV_ADDR, cfg_word(r_idx, iVOL)};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tdiv <= 16'd0;
    end else begin
      r_tdiv <= w_tick ? 16'd0 : r_tdiv + 16'd1;
    end
  end

  i2c_write3 u_i2c (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .i_tick    (w_tick),
    .i_start   (w_go),
    .i_payload (w_payload),
    .i_sda     (ioI2C_SDAT),
    .o_done    (w_xdone),
    .o_ack     (w_ack),
    .o_scl     (w_scl),
    .o_sda_oe  (w_sda_oe)
  );

  assign oI2C_SCLK  = w_scl;
  assign ioI2C_SDAT = w_sda_oe ? 1'b0 : 1'bz;
  assign oCFG_DONE  = r_done;
  assign oCFG_ERR   = r_err;
  assign oIDX       = r_idx;
  assign oBUSY      = (r_state != S_POR_WAIT) &&
                      (r_state != S_DONE) &&
                      (r_state != S_ERROR);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_POR_WAIT;
      r_cnt   <= 16'd0;
      r_idx   <= 4'd0;
      r_retry <= 4'd0;
      r_vol   <= 7'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_vmode <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_retry <= w_retry_n;
      r_vol   <= w_vol_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_vmode <= w_vmode_n;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_retry_n = r_retry;
    w_vol_n   = r_vol;
    w_done_n  = r_done;
    w_err_n   = r_err;
    w_vmode_n = r_vmode;
    w_go      = 1'b0;
    unique case (r_state)
      S_POR_WAIT: begin
        // Track iVOL so the latched copy matches it out of reset
        w_vol_n = iVOL;
        w_cnt_n = r_cnt + 16'd1;
        if ({1'b0, r_cnt} + 17'd1 >= {1'b0, POR_DELAY}) begin
          w_nxt   = S_LOAD;
          w_idx_n = 4'd0;
          w_cnt_n = 16'd0;
        end
      end
      S_LOAD: begin
        w_go    = 1'b1;
        w_vol_n = iVOL;
        w_nxt   = S_XFER;
      end
      S_XFER: begin
        if (w_xdone) w_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_ack == 3'b000) begin
          w_retry_n = 4'd0;
          w_cnt_n   = 16'd0;
          w_nxt     = S_GAP;
        end else if (r_retry < RETRY_MAX) begin
          w_retry_n = r_retry + 4'd1;
          w_nxt     = S_LOAD;
        end else begin
          w_retry_n = 4'd0;
          w_done_n  = 1'b0;
          w_err_n   = 1'b1;
          w_vmode_n = 1'b0;
          w_nxt     = S_ERROR;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_cnt_n = r_cnt + 16'd1;
          if (r_cnt == 16'd3) begin
            w_cnt_n = 16'd0;
            if (r_vmode ? (r_idx == IDX_RHP) : (r_idx == IDX_LAST)) begin
              w_done_n  = 1'b1;
              w_vmode_n = 1'b0;
              w_nxt     = S_DONE;
            end else begin
              w_idx_n = r_idx + 4'd1;
              w_nxt   = S_LOAD;
            end
          end
        end
      end
      S_DONE: begin
        if (iSTART) begin
          w_done_n  = 1'b0;
          w_err_n   = 1'b0;
          w_idx_n   = 4'd0;
          w_retry_n = 4'd0;
          w_vmode_n = 1'b0;
          w_nxt     = S_LOAD;
        end else if (iVOL != r_vol) begin
          w_vol_n = iVOL;
          w_nxt   = S_VOL_UPD;
        end
      end
      S_ERROR: begin
        if (iSTART) begin
          w_done_n  = 1'b0;
          w_err_n   = 1'b0;
          w_idx_n   = 4'd0;
          w_retry_n = 4'd0;
          w_vmode_n = 1'b0;
          w_nxt     = S_LOAD;
        end
      end
      S_VOL_UPD: begin
        w_idx_n   = IDX_LHP;
        w_retry_n = 4'd0;
        w_vmode_n = 1'b1;
        w_nxt     = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_audio_codec_cfg.sv
// Directed bench for audio_codec_cfg with an I2C slave monitor that
// logs each 3-byte write and can NACK chosen transactions.
module tb_audio_codec_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] vol = 7'h79;
  logic       scl;
  wire        sda;
  logic       busy, done, err;
  logic [3:0] idx;
  logic       slv_low = 1'b0;

  int checks = 0;
  int errors = 0;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  audio_codec_cfg #(
    .CLK_FREQ  (8),
    .I2C_FREQ  (1),
    .DEV_ADDR  (8'h34),
    .POR_DELAY (16'd20),
    .MAX_RETRY (2)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iSTART     (start),
    .iVOL       (vol),
    .oI2C_SCLK  (scl),
    .ioI2C_SDAT (sda),
    .oBUSY      (busy),
    .oCFG_DONE  (done),
    .oCFG_ERR   (err),
    .oIDX       (idx)
  );

  // Slave monitor
  logic [23:0] txn_q[$];
  logic        p_scl, p_sda, m_in;
  logic [3:0]  m_bit;
  logic [1:0]  m_byte;
  logic [7:0]  m_sh;
  logic [23:0] m_word;
  int          m_idx;
  int          nack_txn = -1;
  logic        nack_reg_en = 1'b0;
  logic [7:0]  nack_reg_val = 8'h0C;
  logic        nack_now;

  assign nack_now = (nack_txn == m_idx && m_byte == 2'd0) ||
                    (nack_reg_en && m_byte == 2'd1 && m_sh == nack_reg_val);

  always @(negedge clk) begin
    if (!rst_n) begin
      p_scl   <= 1'b1;
      p_sda   <= 1'b1;
      m_in    <= 1'b0;
      m_bit   <= 4'd0;
      m_byte  <= 2'd0;
      m_sh    <= 8'd0;
      m_word  <= 24'd0;
      m_idx   <= 0;
      slv_low <= 1'b0;
    end else begin
      p_scl <= scl;
      p_sda <= sda;
      if (p_scl && scl && p_sda && !sda) begin
        m_in    <= 1'b1;
        m_bit   <= 4'd0;
        m_byte  <= 2'd0;
        m_word  <= 24'd0;
        m_idx   <= txn_q.size();
        slv_low <= 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        if (m_in) txn_q.push_back(m_word);
        m_in <= 1'b0;
      end else if (m_in && !p_scl && scl) begin
        if (m_bit < 4'd8) m_sh <= {m_sh[6:0], sda};
        if (m_bit == 4'd7) m_word <= {m_word[15:0], m_sh[6:0], sda};
        m_bit <= m_bit + 4'd1;
      end else if (m_in && p_scl && !scl) begin
        if (m_bit == 4'd8) begin
          slv_low <= !nack_now;
        end else if (m_bit == 4'd9) begin
          slv_low <= 1'b0;
          m_bit   <= 4'd0;
          m_byte  <= m_byte + 2'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((done || err) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit dropped, seen_busy, ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl",  32'(scl),  32'd1);
    chk("rst_sda",  32'(sda),  32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_idx",  32'(idx),  32'd0);

    // 1: full power-up sequence
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_txn",  32'(txn_q.size()), 32'd0);
    wait_idle("t1_timeout", 8000);
    chk("t1_count", 32'(txn_q.size()), 32'd11);
    chk("t1_first", 32'(txn_q[0]),  32'h341E00);
    chk("t1_lhp",   32'(txn_q[3]),  32'h3405F9);
    chk("t1_rhp",   32'(txn_q[4]),  32'h3407F9);
    chk("t1_pwr",   32'(txn_q[7]),  32'h340C00);
    chk("t1_last",  32'(txn_q[10]), 32'h341201);
    chk("t1_done",  32'(done), 32'd1);
    chk("t1_err",   32'(err),  32'd0);
    chk("t1_busy",  32'(busy), 32'd0);

    // 4: volume change while in DONE
    txn_q.delete();
    dropped   = 1'b0;
    seen_busy = 1'b0;
    ok        = 1'b0;
    @(negedge clk);
    vol = 7'h60;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!done) dropped = 1'b1;
      if (busy) seen_busy = 1'b1;
      if (txn_q.size() == 2 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_timeout", 32'(ok), 32'd1);
    chk("t4_lhp",     32'(txn_q[0]), 32'h3405E0);
    chk("t4_rhp",     32'(txn_q[1]), 32'h3407E0);
    chk("t4_dropped", 32'(dropped), 32'd0);
    chk("t4_busy",    32'(seen_busy), 32'd1);
    repeat (600) @(negedge clk);
    chk("t4_count", 32'(txn_q.size()), 32'd2);
    chk("t4_idle",  32'(busy), 32'd0);

    // 2: single address NACK on idx 5
    txn_q.delete();
    nack_txn = 5;
    pulse_start();
    @(negedge clk);
    wait_idle("t2_timeout", 8000);
    nack_txn = -1;
    chk("t2_count", 32'(txn_q.size()), 32'd12);
    chk("t2_try1",  32'(txn_q[5]), 32'h340812);
    chk("t2_try2",  32'(txn_q[6]), 32'h340812);
    chk("t2_done",  32'(done), 32'd1);
    chk("t2_err",   32'(err),  32'd0);

    // 3: idx 7 always NACKed
    txn_q.delete();
    nack_reg_en = 1'b1;
    pulse_start();
    @(negedge clk);
    wait_idle("t3_timeout", 8000);
    chk("t3_count", 32'(txn_q.size()), 32'd10);
    chk("t3_err",   32'(err),  32'd1);
    chk("t3_done",  32'(done), 32'd0);
    chk("t3_idx",   32'(idx),  32'd7);
    chk("t3_scl",   32'(scl),  32'd1);
    chk("t3_sda",   32'(sda),  32'd1);
    repeat (200) @(negedge clk);
    chk("t3_hold", 32'(txn_q.size()), 32'd10);
    nack_reg_en = 1'b0;
    txn_q.delete();
    pulse_start();
    @(negedge clk);
    chk("t3_errclr", 32'(err),  32'd0);
    chk("t3_idx0",   32'(idx),  32'd0);
    chk("t3_rbusy",  32'(busy), 32'd1);
    wait_idle("t3r_timeout", 8000);
    chk("t3r_count", 32'(txn_q.size()), 32'd11);
    chk("t3r_first", 32'(txn_q[0]), 32'h341E00);
    chk("t3r_done",  32'(done), 32'd1);

    // 5: reset during bit 3 of the second byte
    txn_q.delete();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_in && m_byte == 2'd1 && m_bit == 4'd3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_reach", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_scl",  32'(scl),  32'd1);
    chk("t5_sda",  32'(sda),  32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    txn_q.delete();
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_por", 32'(busy), 32'd0);
    wait_idle("t5_timeout", 8000);
    chk("t5_count", 32'(txn_q.size()), 32'd11);
    chk("t5_first", 32'(txn_q[0]), 32'h341E00);
    chk("t5_lhp",   32'(txn_q[3]), 32'h3405E0);

    // 6: iSTART held through the POR-triggered sequence
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    txn_q.delete();
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (busy && idx == 4'd10) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_reach", 32'(ok), 32'd1);
    start = 1'b0;
    wait_idle("t6_timeout", 2000);
    chk("t6_count", 32'(txn_q.size()), 32'd11);
    chk("t6_done",  32'(done), 32'd1);
    chk("t6_last",  32'(txn_q[10]), 32'h341201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
